// File: rtl/stream_demultiplexer.sv
// stream_demultiplexer: registered 1-to-N valid/ready stream router.
// One input stream carries a per-beat lane index; each beat is delivered to
// exactly one of out_outputs lanes, each of which has a one-entry holding
// register so a stalled lane only blocks beats addressed to it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   input beat accepted when in_valid && in_ready (combinational)
//   in_data    input beat payload
//   in_sel     destination lane index, sampled with in_data
//   out_valid  bit k: lane k holds a beat
//   out_ready  bit k: lane k consumer accepts
//   out_data   lane k payload at [k*in_bitwidth +: in_bitwidth]
//   drop_err   sticky: a beat with an out-of-range in_sel was accepted and dropped
module stream_demultiplexer #(
    parameter int unsigned in_bitwidth = 1,
    parameter int unsigned out_outputs = 16,
    localparam int unsigned log2ofout  = (out_outputs > 1) ? $clog2(out_outputs) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [in_bitwidth-1:0]             in_data,
    input  logic [log2ofout-1:0]               in_sel,
    output logic [out_outputs-1:0]             out_valid,
    input  logic [out_outputs-1:0]             out_ready,
    output logic [in_bitwidth*out_outputs-1:0] out_data,
    output logic                               drop_err
);

    // Per-lane holding registers.
    logic [out_outputs-1:0]                  full_q;
    logic [out_outputs-1:0]                  full_d;
    logic [out_outputs-1:0][in_bitwidth-1:0] data_q;
    logic [out_outputs-1:0][in_bitwidth-1:0] data_d;
    logic                                    drop_err_q;
    logic                                    drop_err_d;

    // Decoded select and handshake terms.
    logic [out_outputs-1:0] sel_hit_c;
    logic                   sel_ok_c;
    logic                   ready_c;
    logic                   accept_c;

    // One-hot decode of in_sel; an index past the last lane hits nothing,
    // which avoids indexing the lane vectors out of range.
    always_comb begin
        sel_hit_c = '0;
        for (int k = 0; k < int'(out_outputs); k++) begin
            sel_hit_c[k] = (in_sel == log2ofout'(k));
        end
        sel_ok_c = |sel_hit_c;
    end

    // Ready looks only at the addressed lane; a lane that drains this cycle
    // can take a new beat on the same edge. Invalid selects are always taken.
    always_comb begin
        ready_c  = !sel_ok_c || (|(sel_hit_c & (~full_q | out_ready)));
        in_ready = rst_n && ready_c;
        accept_c = in_valid && in_ready;
    end

    // Next-state: load/drain per lane, sticky drop flag.
    always_comb begin
        full_d     = full_q;
        data_d     = data_q;
        drop_err_d = drop_err_q;
        for (int k = 0; k < int'(out_outputs); k++) begin
            if (accept_c && sel_hit_c[k]) begin
                full_d[k] = 1'b1;
                data_d[k] = in_data;
            end else if (full_q[k] && out_ready[k]) begin
                full_d[k] = 1'b0;
            end
        end
        if (accept_c && !sel_ok_c) begin
            drop_err_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            data_q     <= '0;
            drop_err_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            data_q     <= data_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Lane payload is kept after a drain; only the valid bit clears.
    assign out_valid = full_q;
    assign out_data  = data_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Testbench for stream_demultiplexer: directed checks on a 4-lane instance,
// out-of-range and randomised scoreboard checks on a 5-lane instance.
module tb_stream_demultiplexer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-lane instance
    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_ready;
    logic [31:0] a_out_data;
    logic        a_drop_err;

    // 5-lane instance
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_data;
    logic [2:0]  b_in_sel;
    logic [4:0]  b_out_valid;
    logic [4:0]  b_out_ready;
    logic [39:0] b_out_data;
    logic        b_drop_err;

    stream_demultiplexer #(.in_bitwidth(8), .out_outputs(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_sel(a_in_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .drop_err(a_drop_err)
    );

    stream_demultiplexer #(.in_bitwidth(8), .out_outputs(5)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sel(b_in_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .drop_err(b_drop_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one FIFO of expected beats per lane, plus drop flag.
    logic [7:0] exp_q [5][$];
    logic       exp_drop;
    logic       mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: just before each rising edge, every lane handshaking must
    // present the oldest outstanding beat for that lane.
    task automatic monitor();
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                for (int k = 0; k < 5; k++) begin
                    if (b_out_valid[k] && b_out_ready[k]) begin
                        if (exp_q[k].size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL rand_spurious lane%0d: got beat 0x%0h expected no beat", k,
                                     b_out_data[k*8 +: 8]);
                        end else begin
                            logic [7:0] e;
                            e = exp_q[k].pop_front();
                            chk($sformatf("rand_lane%0d_data", k), 32'(b_out_data[k*8 +: 8]), 32'(e));
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  accepted;
        int  cyc;
        logic hold;

        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = '0;
        b_in_valid  = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = '0;
        exp_drop    = 1'b0;
        fork monitor(); join_none

        // Reset state
        #3;
        chk("rst_in_ready", 32'(a_in_ready), 0);
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_drop_err", 32'(a_drop_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            a_in_sel = 2'(s);
            #1 chk($sformatf("idle_ready_sel%0d", s), 32'(a_in_ready), 1);
        end

        // Single routing with stall and replace
        @(negedge clk);
        a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 8'hA5; a_out_ready = 4'b0000;
        #1 chk("route_accept_ready", 32'(a_in_ready), 1);
        @(negedge clk);
        a_in_data = 8'h5A;
        #1 chk("route_valid", 32'(a_out_valid), 32'h4);
        chk("route_data", 32'(a_out_data[23:16]), 32'hA5);
        chk("route_stall_ready", 32'(a_in_ready), 0);
        @(negedge clk);
        #1 chk("stall_hold_valid", 32'(a_out_valid), 32'h4);
        chk("stall_hold_data", 32'(a_out_data[23:16]), 32'hA5);
        chk("stall_hold_ready", 32'(a_in_ready), 0);
        a_out_ready = 4'b0100;
        #1 chk("stall_release_ready", 32'(a_in_ready), 1);
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 4'b0000;
        #1 chk("replace_valid", 32'(a_out_valid), 32'h4);
        chk("replace_data", 32'(a_out_data[23:16]), 32'h5A);
        @(negedge clk);
        a_out_ready = 4'b0100;
        @(negedge clk);
        a_out_ready = 4'b0000;
        #1 chk("drain_valid", 32'(a_out_valid), 0);
        chk("drain_data_kept", 32'(a_out_data[23:16]), 32'h5A);

        // Full throughput on lane 1
        a_out_ready = 4'b0010;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_data = 8'(i);
            #1 chk("tput_ready", 32'(a_in_ready), 1);
            if (i > 1) begin
                chk("tput_valid", 32'(a_out_valid), 32'h2);
                chk("tput_data", 32'(a_out_data[15:8]), 32'(i - 1));
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1 chk("tput_last_valid", 32'(a_out_valid), 32'h2);
        chk("tput_last_data", 32'(a_out_data[15:8]), 32'h10);
        @(negedge clk);
        #1 chk("tput_empty", 32'(a_out_valid), 0);

        // Isolation: stalled lane 0 does not block lane 3
        a_out_ready = 4'b0000;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 8'h11;
        @(negedge clk);
        a_in_sel = 2'd3; a_in_data = 8'h33;
        #1 chk("iso_ready", 32'(a_in_ready), 1);
        chk("iso_lane0_only", 32'(a_out_valid), 32'h1);
        @(negedge clk);
        a_in_valid = 1'b0;
        #1 chk("iso_valid", 32'(a_out_valid), 32'h9);
        chk("iso_lane0_data", 32'(a_out_data[7:0]), 32'h11);
        chk("iso_lane3_data", 32'(a_out_data[31:24]), 32'h33);
        a_in_sel = 2'd0;
        #1 chk("iso_lane0_stall", 32'(a_in_ready), 0);

        // Asynchronous reset mid-traffic, checked before the next edge
        rst_n = 1'b0;
        #1 chk("async_rst_valid", 32'(a_out_valid), 0);
        chk("async_rst_data", a_out_data, 0);
        chk("async_rst_ready", 32'(a_in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Out-of-range select on the 5-lane instance
        @(negedge clk);
        b_in_valid = 1'b1; b_in_sel = 3'd6; b_in_data = 8'h77; b_out_ready = 5'b0;
        #1 chk("oor_ready", 32'(b_in_ready), 1);
        chk("oor_drop_before", 32'(b_drop_err), 0);
        @(negedge clk);
        b_in_sel = 3'd4; b_in_data = 8'h44;
        #1 chk("oor_no_valid", 32'(b_out_valid), 0);
        chk("oor_drop_set", 32'(b_drop_err), 1);
        @(negedge clk);
        b_in_valid = 1'b0;
        #1 chk("oor_lane4_valid", 32'(b_out_valid), 32'h10);
        chk("oor_lane4_data", 32'(b_out_data[39:32]), 32'h44);
        chk("oor_drop_sticky", 32'(b_drop_err), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("oor_drop_reset", 32'(b_drop_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised scoreboard, 1000 accepted beats
        mon_en   = 1'b1;
        accepted = 0;
        cyc      = 0;
        hold     = 1'b0;
        exp_drop = 1'b0;
        while (accepted < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_in_sel   = ($urandom_range(0, 11) == 0) ? 3'(5 + $urandom_range(0, 2))
                                                          : 3'($urandom_range(0, 4));
                b_in_data  = 8'($urandom);
            end
            b_out_ready = 5'($urandom) | 5'($urandom);
            #4;
            chk("rand_drop_err", 32'(b_drop_err), 32'(exp_drop));
            if (b_in_valid && b_in_ready) begin
                accepted++;
                if (b_in_sel < 3'd5) exp_q[b_in_sel].push_back(b_in_data);
                else exp_drop = 1'b1;
                hold = 1'b0;
            end else begin
                hold = b_in_valid;
            end
        end
        chk("rand_budget", 32'(accepted), 1000);
        @(negedge clk);
        b_in_valid  = 1'b0;
        b_out_ready = 5'b11111;
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rand_lane%0d_left", k), 32'(exp_q[k].size()), 0);
        end
        chk("rand_final_valid", 32'(b_out_valid), 0);
        chk("rand_final_drop", 32'(b_drop_err), 32'(exp_drop));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_demultiplexer.md
Name: stream_demultiplexer

Overview:
- Registered 1-to-N stream demultiplexer; the routing counterpart of the team's N-to-1 multiplexer.
- Takes one valid/ready input stream and a per-beat destination select, and delivers each beat to exactly one of N output streams.
- Each output lane has its own one-entry holding register, so a stalled lane blocks only beats addressed to it.
- Sits between a shared producer (bus, arbiter output) and per-channel consumers.

Parameters:
- in_bitwidth, 1, width of one data beat.
- out_outputs, 16, number of output lanes (>= 2, need not be a power of two).
- log2ofout, max(1, clog2(out_outputs)), select width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid && in_ready.
- in_data  input  in_bitwidth  input beat.
- in_sel  input  log2ofout  destination lane index, sampled with in_data.
- out_valid  output  out_outputs  bit k = lane k holds a beat.
- out_ready  input  out_outputs  bit k = lane k consumer accepts.
- out_data  output  in_bitwidth*out_outputs  lane k at [k*in_bitwidth +: in_bitwidth].
- drop_err  output  1  sticky flag: a beat with out-of-range in_sel was accepted and discarded.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, drop_err = 0.
  - in_ready is forced 0 while rst_n is low.
  - Beats held at reset assertion are lost; no partial transfer survives reset.
- Per-lane state: full[k] (= out_valid[k]) plus data register. Lane k drains when out_valid[k] && out_ready[k].
- Valid sel (in_sel < out_outputs):
  - in_ready = !full[in_sel] || out_ready[in_sel].
  - This is a combinational path from out_ready to in_ready, by design.
- Invalid sel (in_sel >= out_outputs):
  - in_ready = 1.
  - An accepted beat is discarded and drop_err sets on the next edge.
  - drop_err stays 1 until reset.
- Accept of a beat to lane k:
  - Lane k register loads in_data and out_valid[k] = 1 on the next rising edge.
  - Latency is exactly 1 cycle from accept to out_valid[k].
- Lane update per edge:
  - load && drain: stays full, new data replaces old. Back-to-back throughput is 1 beat/cycle per lane.
  - drain only: out_valid[k] clears.
  - load only: out_valid[k] sets.
  - neither: hold.
- out_data[k] holds the last loaded value while out_valid[k] = 0; it is not cleared on drain.
- Independence: lanes drain in parallel. At most one lane loads per cycle.
- Stall behaviour:
  - in_ready depends only on the lane addressed by the current in_sel.
  - A stalled lane j does not block beats addressed to lane k != j.
  - The producer must hold in_data/in_sel stable while in_valid && !in_ready.
- Invariants:
  - No beat is duplicated or reordered within a lane.
  - Every accepted beat with a valid sel appears on exactly one lane exactly once.
- in_valid = 0: in_ready still reflects in_sel, but no state changes.
- Synthesis: out_outputs lanes each of in_bitwidth flops plus 1 valid flop, plus drop_err.

Test Plan:
- Reset then idle, in_bitwidth=8, out_outputs=4:
  - out_valid=4'b0000, out_data=0, drop_err=0, in_ready=1 for all sel.
  - Assert rst_n low mid-traffic: out_valid clears immediately, without waiting for a clock edge.
- Single routing:
  - Send 0xA5 with sel=2, all out_ready=0.
  - Next cycle out_valid=4'b0100, lane2 data=0xA5.
  - A second beat to sel=2 sees in_ready=0.
  - Raise out_ready[2]: that beat is accepted; lane2 reads 0xA5, then the new beat the following cycle.
- Full throughput:
  - out_ready[1] held 1; stream 0x01..0x10 to sel=1 on consecutive cycles.
  - in_ready stays 1 and lane1 emits 0x01..0x10 in order, one per cycle, with 1-cycle latency.
- Isolation:
  - Lane 0 full with out_ready[0]=0; send 0x33 to sel=3.
  - Accepted in the same cycle, lane3 valid next cycle, lane0 data unchanged.
- Out-of-range select (out_outputs=5, log2ofout=3):
  - Send 0x77 with sel=6: in_ready=1, no out_valid bit sets, drop_err=1 next cycle and remains 1 through further valid traffic.
- Randomised scoreboard, 1000 beats:
  - Random sel/valid/ready; per-lane queues match in order.
  - No loss, no duplication.
